// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state encoding and default widths for the Fibonacci scheduler
package fib_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fib_state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_CW   = 4;
  localparam int DEF_VW   = 16;
endpackage

// File: rtl/fib_core.sv
// rtl/fib_core.sv - cur/prev/cnt Fibonacci datapath shared by all requesters
module fib_core
  import fib_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [CW-1:0] load_count,
  output logic [VW-1:0] cur,
  output logic          cnt_zero
);
  logic [CW-1:0] cnt;
  logic [VW-1:0] prev;

  // step is ignored once the count is exhausted, so cur holds the final value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      cur  <= '0;
      prev <= '0;
    end else if (load) begin
      cnt  <= load_count;
      cur  <= VW'(1);
      prev <= '0;
    end else if (step && (cnt != '0)) begin
      cnt  <= cnt - 1'b1;
      prev <= cur;
      cur  <= cur + prev;
    end
  end

  assign cnt_zero = (cnt == '0);
endmodule

// File: rtl/fib_sched.sv
// rtl/fib_sched.sv - round-robin grant FSM sequencing one shared Fibonacci engine
module fib_sched
  import fib_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW,
  parameter int VW   = DEF_VW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] req_count,
  output logic [NREQ-1:0]  ack,
  output logic [NREQ-1:0]  done,
  output logic [VW-1:0]    result,
  output logic             busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  fib_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] idx;
  logic [IW-1:0] winner;
  logic          any_req;
  logic [CW-1:0] win_count;
  logic          load;
  logic [VW-1:0] cur;
  logic          cnt_zero;

  // first set request at or above rr_ptr, wrapping around
  always_comb begin
    any_req = 1'b0;
    winner  = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_req && req[(int'(rr_ptr) + k) % NREQ]) begin
        any_req = 1'b1;
        winner  = IW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign win_count = req_count[int'(winner)*CW +: CW];
  assign load      = (state == IDLE) && any_req;

  fib_core #(.CW(CW), .VW(VW)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (state == RUN),
    .load_count (win_count),
    .cur        (cur),
    .cnt_zero   (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      idx    <= '0;
      ack    <= '0;
      done   <= '0;
      result <= '0;
      busy   <= 1'b0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            idx    <= winner;
            rr_ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
            ack    <= NREQ'(1) << winner;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (cnt_zero) begin
            result <= cur;
            done   <= NREQ'(1) << idx;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fib_sched.sv
// tb/tb_fib_sched.sv - directed self-checking bench for fib_sched
module tb_fib_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] req_count = '0;
  logic [3:0]  ack, done;
  logic [15:0] result;
  logic        busy;

  logic [3:0]  req8 = '0;
  logic [15:0] req_count8 = '0;
  logic [3:0]  ack8, done8;
  logic [7:0]  result8;
  logic        busy8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fib_sched #(.NREQ(4), .CW(4), .VW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_count(req_count),
    .ack(ack), .done(done), .result(result), .busy(busy)
  );

  fib_sched #(.NREQ(4), .CW(4), .VW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .req_count(req_count8),
    .ack(ack8), .done(done8), .result(result8), .busy(busy8)
  );

  task automatic wait_ack(output int who);
    who = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ack != 0) begin
        who = -2;
        for (int i = 0; i < 4; i++) if (ack == (4'b1 << i)) who = i;
        break;
      end
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done != 0) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ack !== 4'b0) $display("FAIL reset_ack got=%b exp=0000", ack); else passed++;
    total++; if (done !== 4'b0) $display("FAIL reset_done got=%b exp=0000", done); else passed++;
    total++; if (result !== 16'd0) $display("FAIL reset_result got=%0d exp=0", result); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int who, lat;
    req_count = 16'h000A;
    req = 4'b0001;
    wait_ack(who);
    req = 4'b0000;
    total++; if (who !== 0) $display("FAIL single_ack got=%0d exp=0", who); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL single_busy_run got=%b exp=1", busy); else passed++;
    wait_done(lat);
    total++; if (lat !== 11) $display("FAIL single_latency got=%0d exp=11", lat); else passed++;
    total++; if (done !== 4'b0001) $display("FAIL single_done got=%b exp=0001", done); else passed++;
    total++; if (result !== 16'd89) $display("FAIL single_result got=%0d exp=89", result); else passed++;
    total++; if (ack !== 4'b0) $display("FAIL single_ack_done_overlap got=%b exp=0000", ack); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL single_busy_after got=%b exp=0", busy); else passed++;
    total++; if (done !== 4'b0) $display("FAIL single_done_pulse got=%b exp=0000", done); else passed++;
    total++; if (result !== 16'd89) $display("FAIL single_result_hold got=%0d exp=89", result); else passed++;
  endtask

  task automatic test_count_edges();
    int who, lat;
    req_count = 16'h0000;
    req = 4'b0100;
    wait_ack(who);
    req = 4'b0000;
    total++; if (who !== 2) $display("FAIL zero_ack got=%0d exp=2", who); else passed++;
    wait_done(lat);
    total++; if (lat !== 1) $display("FAIL zero_latency got=%0d exp=1", lat); else passed++;
    total++; if (done !== 4'b0100) $display("FAIL zero_done got=%b exp=0100", done); else passed++;
    total++; if (result !== 16'd1) $display("FAIL zero_result got=%0d exp=1", result); else passed++;
    req_count = 16'h0F00;
    req = 4'b0100;
    wait_ack(who);
    req = 4'b0000;
    req_count = 16'h0300;
    wait_done(lat);
    total++; if (lat !== 16) $display("FAIL max_latency got=%0d exp=16", lat); else passed++;
    total++; if (result !== 16'd987) $display("FAIL max_result got=%0d exp=987", result); else passed++;
  endtask

  task automatic test_all_four();
    int who, lat;
    int exp_res [4] = '{1, 2, 3, 5};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_count = 16'h4321;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(who);
      total++; if (who !== i) $display("FAIL rr_grant_%0d got=%0d exp=%0d", i, who, i); else passed++;
      wait_done(lat);
      total++; if (done !== (4'b1 << i)) $display("FAIL rr_done_%0d got=%b exp=%b", i, done, 4'b1 << i); else passed++;
      total++; if (result !== 16'(exp_res[i])) $display("FAIL rr_result_%0d got=%0d exp=%0d", i, result, exp_res[i]); else passed++;
      req[i] = 1'b0;
    end
    req_count = 16'h2003;
    req = 4'b1001;
    wait_ack(who);
    total++; if (who !== 0) $display("FAIL wrap_first got=%0d exp=0", who); else passed++;
    wait_done(lat);
    total++; if (result !== 16'd3) $display("FAIL wrap_first_result got=%0d exp=3", result); else passed++;
    req[0] = 1'b0;
    wait_ack(who);
    total++; if (who !== 3) $display("FAIL wrap_second got=%0d exp=3", who); else passed++;
    wait_done(lat);
    total++; if (result !== 16'd2) $display("FAIL wrap_second_result got=%0d exp=2", result); else passed++;
    req[3] = 1'b0;
  endtask

  task automatic test_rr_ptr2();
    int who, lat;
    req_count = 16'h0000;
    req = 4'b0010;
    wait_ack(who);
    req = 4'b0000;
    wait_done(lat);
    total++; if (who !== 1) $display("FAIL ptr2_setup got=%0d exp=1", who); else passed++;
    req_count = 16'h6050;
    req = 4'b1010;
    wait_ack(who);
    total++; if (who !== 3) $display("FAIL ptr2_first got=%0d exp=3", who); else passed++;
    wait_done(lat);
    total++; if (result !== 16'd13) $display("FAIL ptr2_first_result got=%0d exp=13", result); else passed++;
    req[3] = 1'b0;
    wait_ack(who);
    total++; if (who !== 1) $display("FAIL ptr2_second got=%0d exp=1", who); else passed++;
    wait_done(lat);
    total++; if (result !== 16'd8) $display("FAIL ptr2_second_result got=%0d exp=8", result); else passed++;
    req[1] = 1'b0;
  endtask

  task automatic test_narrow_wrap();
    int lat;
    req_count8 = 16'h000F;
    req8 = 4'b0001;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ack8 != 0) req8 = 4'b0000;
      if (done8 != 0) begin
        lat = n;
        break;
      end
    end
    total++; if (lat < 0) $display("FAIL vw8_timeout got=%0d exp=done", lat); else passed++;
    total++; if (done8 !== 4'b0001) $display("FAIL vw8_done got=%b exp=0001", done8); else passed++;
    total++; if (result8 !== 8'd219) $display("FAIL vw8_result got=%0d exp=219", result8); else passed++;
    repeat (2) @(negedge clk);
    total++; if (busy8 !== 1'b0) $display("FAIL vw8_busy_after got=%b exp=0", busy8); else passed++;
    total++; if (result8 !== 8'd219) $display("FAIL vw8_result_hold got=%0d exp=219", result8); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int who, lat, ndone;
    req_count = 16'h000A;
    req = 4'b0001;
    wait_ack(who);
    req = 4'b0000;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passed++;
    total++; if (result !== 16'd0) $display("FAIL abort_result got=%0d exp=0", result); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done != 0) ndone++;
    end
    total++; if (ndone !== 0) $display("FAIL abort_no_done got=%0d exp=0", ndone); else passed++;
    req_count = 16'h0030;
    req = 4'b0010;
    wait_ack(who);
    req = 4'b0000;
    total++; if (who !== 1) $display("FAIL after_reset_ack got=%0d exp=1", who); else passed++;
    wait_done(lat);
    total++; if (lat !== 4) $display("FAIL after_reset_latency got=%0d exp=4", lat); else passed++;
    total++; if (result !== 16'd3) $display("FAIL after_reset_result got=%0d exp=3", result); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_count_edges();
    test_all_four();
    test_rr_ptr2();
    test_narrow_wrap();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
